// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: timer state encoding,
// the hard-wired zero register and default mul/div latencies.
package pipeline_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } muldiv_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_MULT_CYCLES = 4;
  localparam int DEF_DIV_CYCLES  = 32;
  localparam int DEF_CNT_WIDTH   = 6;

endpackage

// File: rtl/pipeline_stall_ctrl_muldiv_timer.sv
// Occupancy timer for the multi-cycle mul/div unit: busy for N cycles after a start,
// done pulses in the last busy cycle. Starts arriving while busy are ignored.
module muldiv_timer
  import pipeline_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_WIDTH-1:0] MULT_LOAD = CNT_WIDTH'(MULT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(DIV_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;

  muldiv_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          count_d = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      ST_BUSY: begin
        busy    = 1'b1;
        count_d = count_q - CNT_ONE;
        // Last busy cycle: HI/LO gets written here, unit is free next cycle.
        if (count_q == CNT_ONE) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller for the IF/ID and ID/EX registers and PC hold.
// Outputs are combinational from inputs and the mul/div timer; all forced low during reset.
module pipeline_stall_ctrl
  import pipeline_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_hilo_access,
  input  logic       id_branch_taken,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       ex_muldiv_start,
  input  logic       ex_muldiv_is_div,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       clear_decode,
  output logic       clear_execute,
  output logic       muldiv_busy,
  output logic       muldiv_done
);

  logic timer_busy;
  logic timer_done;
  logic load_use;
  logic hilo_stall;
  logic stall;

  muldiv_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_muldiv_timer (
    .clock  (clock),
    .reset  (reset),
    .start  (ex_muldiv_start),
    .is_div (ex_muldiv_is_div),
    .busy   (timer_busy),
    .done   (timer_done)
  );

  always_comb begin
    load_use   = ex_mem_read && (ex_rt != REG_ZERO) &&
                 ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    hilo_stall = timer_busy && id_hilo_access;
    stall      = load_use || hilo_stall;

    // A stalled branch is not flushed; decode holds and it resolves again next cycle.
    stall_fetch   = !reset && stall;
    stall_decode  = !reset && stall;
    clear_execute = !reset && stall;
    clear_decode  = !reset && id_branch_taken && !stall;
    muldiv_busy   = !reset && timer_busy;
    muldiv_done   = !reset && timer_done;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized and directed bench for pipeline_stall_ctrl against a cycle-window reference model.
module tb_pipeline_stall_ctrl;

  localparam int MC = 4;
  localparam int DC = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_hilo_access, id_branch_taken;
  logic       ex_mem_read, ex_muldiv_start, ex_muldiv_is_div;
  logic       stall_fetch, stall_decode, clear_decode, clear_execute;
  logic       muldiv_busy, muldiv_done;
  logic [5:0] obs;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  // Model: the unit is occupied in cycles (op_start, op_end]; op_end is the done cycle.
  int op_start = 0;
  int op_end   = -1;

  pipeline_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_WIDTH(6)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_hilo_access(id_hilo_access), .id_branch_taken(id_branch_taken),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_muldiv_start(ex_muldiv_start), .ex_muldiv_is_div(ex_muldiv_is_div),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .clear_decode(clear_decode), .clear_execute(clear_execute),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
  );

  always #5 clock = ~clock;

  assign obs = {stall_fetch, stall_decode, clear_decode, clear_execute, muldiv_busy, muldiv_done};

  function automatic logic m_busy();
    return (cyc > op_start) && (cyc <= op_end);
  endfunction

  function automatic logic [5:0] exp_out();
    logic lu, st, b, d;
    if (reset) return 6'b0;
    lu = ex_mem_read && (ex_rt != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    b  = m_busy();
    d  = b && (cyc == op_end);
    st = lu || (b && id_hilo_access);
    return {st, st, id_branch_taken && !st, st, b, d};
  endfunction

  task automatic tick();
    if (!reset && ex_muldiv_start && !m_busy()) begin
      op_start = cyc;
      op_end   = cyc + (ex_muldiv_is_div ? DC : MC);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_hilo_access = 1'b0; id_branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_muldiv_start = 1'b0; ex_muldiv_is_div = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; id_branch_taken = 1'b1;
    #3;
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_forced got=%b want=%b", obs, 6'b0); end
    tick(); tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_release got=%b want=%b", obs, 6'b0); end
    tick();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== 6'b110100) begin errors++; $display("FAIL load_use_rs got=%b want=%b", obs, 6'b110100); end
    tick();
    ex_mem_read = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL load_use_drop got=%b want=%b", obs, 6'b0); end
    tick();
    ex_mem_read = 1'b1; id_uses_rs = 1'b0; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== 6'b110100) begin errors++; $display("FAIL load_use_rt got=%b want=%b", obs, 6'b110100); end
    tick();
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL zero_reg got=%b want=%b", obs, 6'b0); end
    tick();
    ex_rt = 5'd8; id_rs = 5'd1; id_rt = 5'd8; id_uses_rt = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL unused_rt got=%b want=%b", obs, 6'b0); end
    tick();
    idle_inputs();
  endtask

  task automatic test_multiply();
    int nbusy = 0, ndone = 0, done_k = -1, nstall = 0;
    ex_muldiv_start = 1'b1; ex_muldiv_is_div = 1'b0; id_hilo_access = 1'b1;
    for (int k = 0; k <= MC + 1; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL mult_cycle k=%0d got=%b want=%b", k, obs, exp_out());
      end
      if (muldiv_busy) nbusy++;
      if (muldiv_done) begin ndone++; done_k = k; end
      if (stall_fetch) nstall++;
      if (k == MC + 1) begin
        checks++;
        if (stall_fetch !== 1'b0) begin errors++; $display("FAIL mult_after got=%b want=0", stall_fetch); end
      end
      tick();
      ex_muldiv_start = 1'b0;
    end
    checks++;
    if (nbusy != MC) begin errors++; $display("FAIL mult_busy_len got=%0d want=%0d", nbusy, MC); end
    checks++;
    if (ndone != 1 || done_k != MC) begin
      errors++; $display("FAIL mult_done got=%0d@%0d want=1@%0d", ndone, done_k, MC);
    end
    checks++;
    if (nstall != MC) begin errors++; $display("FAIL mult_stall_len got=%0d want=%0d", nstall, MC); end
    idle_inputs();
  endtask

  task automatic test_div_then_mult();
    int nbusy = 0, nstall = 0;
    int dones[$];
    ex_muldiv_start = 1'b1; ex_muldiv_is_div = 1'b1;
    for (int k = 0; k <= DC + MC + 3; k++) begin
      if (k == DC + 1) begin ex_muldiv_start = 1'b1; ex_muldiv_is_div = 1'b0; end
      @(negedge clock);
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL divmul_cycle k=%0d got=%b want=%b", k, obs, exp_out());
      end
      if (muldiv_busy) nbusy++;
      if (muldiv_done) dones.push_back(k);
      if (stall_fetch) nstall++;
      tick();
      ex_muldiv_start = 1'b0;
    end
    checks++;
    if (nbusy != DC + MC) begin errors++; $display("FAIL divmul_busy got=%0d want=%0d", nbusy, DC + MC); end
    checks++;
    if (dones.size() != 2 || dones[0] != DC || dones[1] != DC + 1 + MC) begin
      errors++; $display("FAIL divmul_done got_n=%0d want=2 at %0d,%0d", dones.size(), DC, DC + 1 + MC);
    end
    checks++;
    if (nstall != 0) begin errors++; $display("FAIL divmul_nostall got=%0d want=0", nstall); end
    idle_inputs();
  endtask

  task automatic test_branch_vs_stall();
    id_branch_taken = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== 6'b001000) begin errors++; $display("FAIL branch_alone got=%b want=%b", obs, 6'b001000); end
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
    @(negedge clock);
    checks++;
    if (obs !== 6'b110100) begin errors++; $display("FAIL branch_stall got=%b want=%b", obs, 6'b110100); end
    tick();
    ex_mem_read = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== 6'b001000) begin errors++; $display("FAIL branch_retry got=%b want=%b", obs, 6'b001000); end
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    int nbusy = 0, ndone = 0;
    ex_muldiv_start = 1'b1; ex_muldiv_is_div = 1'b1; id_hilo_access = 1'b1;
    tick();
    ex_muldiv_start = 1'b0;
    // Advance to the cycle where 17 cycles of the divide remain.
    for (int k = 1; k < DC - 16; k++) tick();
    @(negedge clock);
    checks++;
    if (obs !== 6'b110110) begin errors++; $display("FAIL div_midway got=%b want=%b", obs, 6'b110110); end
    @(posedge clock); #1; cyc++;
    #2;
    reset = 1'b1;
    op_end = -1;
    #1;
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL async_reset got=%b want=%b", obs, 6'b0); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < DC; k++) begin
      @(negedge clock);
      if (muldiv_busy) nbusy++;
      if (muldiv_done) ndone++;
      tick();
    end
    checks++;
    if (nbusy != 0 || ndone != 0) begin
      errors++; $display("FAIL reset_abandon busy=%0d done=%0d want=0,0", nbusy, ndone);
    end
    ex_muldiv_start = 1'b1; ex_muldiv_is_div = 1'b0; id_hilo_access = 1'b0;
    nbusy = 0; ndone = 0;
    for (int k = 0; k <= MC + 1; k++) begin
      @(negedge clock);
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL post_reset_mult k=%0d got=%b want=%b", k, obs, exp_out());
      end
      if (muldiv_busy) nbusy++;
      if (muldiv_done) ndone++;
      tick();
      ex_muldiv_start = 1'b0;
    end
    checks++;
    if (nbusy != MC || ndone != 1) begin
      errors++; $display("FAIL post_reset_len busy=%0d done=%0d want=%0d,1", nbusy, ndone, MC);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      id_rs            = 5'($urandom_range(0, 3));
      id_rt            = 5'($urandom_range(0, 3));
      ex_rt            = 5'($urandom_range(0, 3));
      id_uses_rs       = 1'($urandom_range(0, 1));
      id_uses_rt       = 1'($urandom_range(0, 1));
      id_hilo_access   = 1'($urandom_range(0, 1));
      id_branch_taken  = 1'($urandom_range(0, 1));
      ex_mem_read      = 1'($urandom_range(0, 1));
      ex_muldiv_start  = ($urandom_range(0, 7) == 0);
      ex_muldiv_is_div = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      checks++;
      if (obs !== exp_out()) begin
        errors++; $display("FAIL random k=%0d got=%b want=%b", k, obs, exp_out());
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_multiply();
    test_div_then_mult();
    test_branch_vs_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
